mod_dec_invmixcolumns: RTL and testbench
========================================

Name: mod_dec_invmixcolumns

Overview:
Decryption-side counterpart of the encryption MixColumns multiplicator. It applies the AES InvMixColumns transform to a 128-bit state, multiplying each column by the fixed GF(2^8) matrix [0e 0b 0d 09] (circulant). It is iterative, processing COLS_PER_CYCLE columns per clock, with valid/ready handshakes on both sides. It sits in the decryption round datapath between InvAddRoundKey and InvShiftRows/InvSubBytes.

Parameters:
N, 16, state width in bytes; fixed at 16, other values are illegal and trigger an elaboration error.
COLS_PER_CYCLE, 1, columns transformed per clock; legal values are 1, 2 and 4. Compute latency is 4/COLS_PER_CYCLE cycles.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low
i_valid  input  1  input state valid
o_ready  output  1  block can accept an input state
i_data  input  [N-1:0][7:0]  input state; byte index 4*c+r = column c, row r
o_valid  output  1  result valid
i_ready  input  1  downstream accepts the result
o_data  output  [N-1:0][7:0]  InvMixColumns result, same byte ordering as i_data
o_busy  output  1  high in BUSY state

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, column counter=0, o_data=0, o_valid=0, o_busy=0, o_ready=1 once rst is released. Reset mid-operation discards the in-flight state; no partial result is ever presented.
- FSM states are IDLE, BUSY and DONE.
- IDLE:
  - o_ready=1.
  - Accept on the rising edge where i_valid && o_ready. i_data is captured into the source register, counter=0, next state is BUSY.
- BUSY:
  - Each cycle, columns counter..counter+COLS_PER_CYCLE-1 of the source register are transformed and written into the matching byte slots of the result register.
  - counter += COLS_PER_CYCLE.
  - When the final group is written, next state is DONE.
  - o_ready=0. i_valid is ignored.
- DONE:
  - o_valid=1 and o_data holds the full result. It stays stable until handshake (o_valid && i_ready).
  - On handshake with no new input, next state is IDLE and o_valid drops the next cycle.
- Back-to-back: in DONE, o_ready = i_ready. If i_valid && i_ready in the same cycle, the result is consumed, the new state is captured, and next state is BUSY. No bubble is inserted on the input side.
- Latency: o_valid rises exactly 4/COLS_PER_CYCLE rising edges after the accept edge (4 for the default). Minimum throughput is one state every 4/COLS_PER_CYCLE+1 cycles with i_ready held high.
- Stall: while in DONE with i_ready=0, o_ready=0, o_data is unchanged and i_data is not sampled.
- Arithmetic:
  - Each output byte is the XOR of four GF(2^8) products, reduced by polynomial 0x11B.
  - xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1B : 8'h00).
  - x09 = x8^x1, x0b = x8^x2^x1, x0d = x8^x4^x1, x0e = x8^x4^x2.
  - Row r output = 0e*a[r] ^ 0b*a[r+1] ^ 0d*a[r+2] ^ 09*a[r+3], indices mod 4.
  - All 8-bit; no carry output exists.
- o_data is registered; it changes only on the edge that writes a column group or on reset.
- o_busy = (state==BUSY).

Decomposition:
- Package aes_pkg:
  - typedef logic [15:0][7:0] aes_state_t; typedef logic [3:0][7:0] aes_col_t.
  - localparam AES_POLY = 8'h1B.
  - Functions xtime and gf_mul_const (constant 09/0b/0d/0e).
  - FSM state enum {IDLE, BUSY, DONE}.
- Sub-module mod_dec_invmixcol_column: combinational, aes_col_t in, aes_col_t out. The top instantiates COLS_PER_CYCLE copies via generate, with column-select muxes driven by the counter.

Test Plan:
- Reset then single column pattern: column 0 = 8e 4d a1 bc (rows 0..3), other columns 00 -> after 4 cycles o_valid=1, column 0 = db 13 53 45, others 00.
- Full state, columns {d5 d5 d7 d6}, {4d 7e bd f8}, {9f dc 58 9d}, {c6 c6 c6 c6} -> o_data columns {d4 d4 d4 d5}, {2d 26 31 4c}, {f2 0a 22 5c}, {c6 c6 c6 c6}. Latency 4 for COLS_PER_CYCLE=1, 2 for =2, 1 for =4.
- Backpressure: i_ready=0 for 10 cycles after o_valid -> o_data stable, o_ready=0, a new i_valid is not accepted. Releasing i_ready consumes the result in one cycle.
- Back-to-back: two states queued, i_ready=1 -> second accept on the same edge as the first handshake; results in order; spacing of 5 cycles between o_valid pulses (default).
- Reset mid-BUSY: assert rst=0 two cycles after accept -> o_valid=0, o_data=00..00 immediately. After release, o_ready=1 and the next state of all 01 yields all 01.
- Random round-trip: 1000 random states through the encryption multiplicator, then this block -> output equals the original state.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES types, GF(2^8) helpers and the iterative-transform FSM encoding.
package aes_pkg;

  typedef logic [15:0][7:0] aes_state_t;
  typedef logic [3:0][7:0]  aes_col_t;

  localparam logic [7:0] AES_POLY = 8'h1B;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  // Only the InvMixColumns coefficients are supported; anything else yields zero.
  function automatic logic [7:0] gf_mul_const(input logic [7:0] b, input logic [7:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    case (k)
      8'h09:   return x8 ^ b;
      8'h0b:   return x8 ^ x2 ^ b;
      8'h0d:   return x8 ^ x4 ^ b;
      8'h0e:   return x8 ^ x4 ^ x2;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/mod_dec_invmixcol_column.sv
// Combinational InvMixColumns for one 4-byte column (row r = byte r).
module mod_dec_invmixcol_column
  import aes_pkg::*;
(
  input  aes_col_t i_col,
  output aes_col_t o_col
);

  for (genvar r = 0; r < 4; r++) begin : g_row
    always_comb begin
      o_col[r] = gf_mul_const(i_col[r],           8'h0e)
               ^ gf_mul_const(i_col[(r + 1) % 4], 8'h0b)
               ^ gf_mul_const(i_col[(r + 2) % 4], 8'h0d)
               ^ gf_mul_const(i_col[(r + 3) % 4], 8'h09);
    end
  end

endmodule

// File: rtl/mod_dec_invmixcolumns.sv
// Iterative AES InvMixColumns: COLS_PER_CYCLE columns per clock, valid/ready on both sides.
module mod_dec_invmixcolumns
  import aes_pkg::*;
#(
  parameter int N              = 16,
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [N-1:0][7:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [N-1:0][7:0] o_data,
  output logic              o_busy
);

  if (N != 16) begin : g_bad_n
    $error("mod_dec_invmixcolumns: N must be 16");
  end
  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cpc
    $error("mod_dec_invmixcolumns: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);

  fsm_state_t state_q, state_d;
  aes_state_t src_q, src_d;
  aes_state_t res_q, res_d;
  logic [1:0] cnt_q, cnt_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;
  logic       accept;

  logic [1:0] sel     [COLS_PER_CYCLE];
  aes_col_t   col_in  [COLS_PER_CYCLE];
  aes_col_t   col_out [COLS_PER_CYCLE];

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    always_comb begin
      sel[g]    = cnt_q + 2'(g);
      col_in[g] = src_q[4*sel[g] +: 4];
    end

    mod_dec_invmixcol_column u_col (
      .i_col (col_in[g]),
      .o_col (col_out[g])
    );
  end

  // In DONE the consumer's ready is forwarded so a new state can enter on the handshake edge.
  always_comb begin
    o_ready = (state_q == IDLE) || ((state_q == DONE) && i_ready);
    accept  = i_valid && o_ready;
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          src_d   = i_data;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int unsigned g = 0; g < COLS_PER_CYCLE; g++) begin
          res_d[4*sel[g] +: 4] = col_out[g];
        end
        cnt_d = cnt_q + STEP;
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        if (i_ready) begin
          if (i_valid) begin
            src_d   = i_data;
            cnt_d   = '0;
            state_d = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == DONE);
    busy_d  = (state_d == BUSY);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    o_data  = res_q;
    o_valid = valid_q;
    o_busy  = busy_q;
  end

endmodule

// File: tb/tb_mod_dec_invmixcolumns.sv
// Bench for mod_dec_invmixcolumns: known vectors, backpressure, back-to-back, reset, random round-trip.
module tb_mod_dec_invmixcolumns;

  localparam int CPC = 1;
  localparam int LAT = 4 / CPC;

  typedef logic [15:0][7:0] st_t;
  typedef struct {
    st_t din;
    st_t dout;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic i_valid = 1'b0;
  logic i_ready = 1'b0;
  st_t  i_data = '0;
  logic o_ready, o_valid, o_busy;
  st_t  o_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mod_dec_invmixcolumns #(.N(16), .COLS_PER_CYCLE(CPC)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_busy  (o_busy)
  );

  // Generic shift-and-add GF(2^8) multiply, reduction polynomial 0x11B.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1B) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  // Circulant column matrix: row r = k[0]*a[r] ^ k[1]*a[r+1] ^ k[2]*a[r+2] ^ k[3]*a[r+3].
  function automatic st_t xform(input st_t s, input logic [31:0] kk);
    st_t o;
    logic [7:0] k [4];
    for (int j = 0; j < 4; j++) k[j] = kk[31-8*j -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        o[4*c+r] = '0;
        for (int j = 0; j < 4; j++) o[4*c+r] ^= gf_mul(s[4*c+((r+j)%4)], k[j]);
      end
    return o;
  endfunction

  function automatic st_t mk(input logic [31:0] c0, input logic [31:0] c1,
                             input logic [31:0] c2, input logic [31:0] c3);
    st_t s;
    logic [31:0] cols [4];
    cols[0] = c0; cols[1] = c1; cols[2] = c2; cols[3] = c3;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[4*c+r] = cols[c][31-8*r -: 8];
    return s;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!o_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_one(input st_t d, output st_t q, output int lat);
    @(negedge clk);
    i_data  = d;
    i_valid = 1'b1;
    chk("ready_before_accept", 128'(o_ready), 128'(1));
    @(posedge clk); #1;
    i_valid = 1'b0;
    wait_valid(lat);
    q = o_data;
    @(negedge clk);
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [4];
    st_t  q, a, b, s, m;
    int   lat, n_acc;
    int   out_cyc [$];
    int   acc_cyc [$];
    st_t  out_dat [$];

    tbl[0].din  = mk(32'h8e4da1bc, 32'h0, 32'h0, 32'h0);
    tbl[0].dout = mk(32'hdb135345, 32'h0, 32'h0, 32'h0);
    tbl[1].din  = mk(32'hd5d5d7d6, 32'h4d7ebdf8, 32'h9fdc589d, 32'hc6c6c6c6);
    tbl[1].dout = mk(32'hd4d4d4d5, 32'h2d26314c, 32'hf20a225c, 32'hc6c6c6c6);
    tbl[2].din  = {16{8'h01}};
    tbl[2].dout = {16{8'h01}};
    tbl[3].din  = {16{8'hff}};
    tbl[3].dout = {16{8'hff}};

    #1;
    chk("reset_o_valid", 128'(o_valid), 128'(0));
    chk("reset_o_data",  o_data,        '0);
    chk("reset_o_busy",  128'(o_busy),  128'(0));
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("post_reset_o_ready", 128'(o_ready), 128'(1));

    for (int i = 0; i < 4; i++) begin
      run_one(tbl[i].din, q, lat);
      chk($sformatf("vec%0d_data", i), q, tbl[i].dout);
      chk($sformatf("vec%0d_latency", i), 128'(lat), 128'(LAT));
      chk($sformatf("vec%0d_valid_drop", i), 128'(o_valid), 128'(0));
    end

    // Backpressure: result held while a competing input waits.
    a = tbl[1].din;
    @(negedge clk);
    i_data = a; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    wait_valid(lat);
    chk("bp_latency", 128'(lat), 128'(LAT));
    i_data = tbl[0].din; i_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_data_stable", o_data, tbl[1].dout);
      chk("bp_o_ready_low", 128'(o_ready), 128'(0));
      chk("bp_o_valid_high", 128'(o_valid), 128'(1));
    end
    @(negedge clk);
    i_valid = 1'b0; i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
    chk("bp_release_valid", 128'(o_valid), 128'(0));
    chk("bp_not_accepted", 128'(o_busy), 128'(0));
    chk("bp_idle_ready", 128'(o_ready), 128'(1));

    // Back-to-back with i_ready held high.
    a = tbl[1].din; b = tbl[0].din;
    n_acc = 0;
    @(negedge clk);
    i_data = a; i_valid = 1'b1; i_ready = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (cyc != 0) @(negedge clk);
      if (o_valid && i_ready) begin
        out_cyc.push_back(cyc);
        out_dat.push_back(o_data);
      end
      if (i_valid && o_ready) begin
        acc_cyc.push_back(cyc);
        n_acc++;
      end
      @(posedge clk); #1;
      if (n_acc == 1) i_data = b;
      if (n_acc >= 2) i_valid = 1'b0;
    end
    i_ready = 1'b0;
    chk("b2b_num_results", 128'(out_cyc.size()), 128'(2));
    chk("b2b_num_accepts", 128'(acc_cyc.size()), 128'(2));
    if (out_cyc.size() == 2 && acc_cyc.size() == 2) begin
      chk("b2b_first_data", out_dat[0], tbl[1].dout);
      chk("b2b_second_data", out_dat[1], tbl[0].dout);
      chk("b2b_spacing", 128'(out_cyc[1] - out_cyc[0]), 128'(LAT + 1));
      chk("b2b_accept_on_handshake", 128'(acc_cyc[1]), 128'(out_cyc[0]));
    end

    // Reset in the middle of BUSY.
    @(negedge clk);
    i_data = tbl[1].din; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midreset_o_valid", 128'(o_valid), 128'(0));
    chk("midreset_o_data",  o_data,        '0);
    chk("midreset_o_busy",  128'(o_busy),  128'(0));
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midreset_o_ready", 128'(o_ready), 128'(1));
    run_one({16{8'h01}}, q, lat);
    chk("after_reset_data", q, {16{8'h01}});
    chk("after_reset_latency", 128'(lat), 128'(LAT));

    // Random round-trip through a reference MixColumns.
    for (int i = 0; i < 1000; i++) begin
      s = {$urandom, $urandom, $urandom, $urandom};
      m = xform(s, 32'h02030101);
      run_one(m, q, lat);
      chk("roundtrip", q, s);
      if (i < 50) chk("roundtrip_latency", 128'(lat), 128'(LAT));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
